// File: rtl/gray_counter_ud_if.sv
// Purpose: control and status bundle for the up/down Gray counter.
// Latency: none, wires only.
// Backpressure: none; en gates stepping and the status outputs are always valid.
interface gray_counter_ud_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             wrap;

    // Driver side: issues commands and observes the count.
    modport master (
        output en, up, load, load_gray,
        input  gray, bin, wrap
    );

    // Counter side: accepts commands and publishes the count.
    modport slave (
        input  en, up, load, load_gray,
        output gray, bin, wrap
    );
endinterface

// File: rtl/gray_counter_ud.sv
// Purpose: parametrised up/down Gray counter with Gray-coded load and a wrap pulse (saturating variant under GRAY_COUNTER_SATURATE_EN).
// Latency: 1 cycle; gray, bin and wrap are registered and update together.
// Backpressure: none; en=0 holds the count, one step per cycle while en=1.
module gray_counter_ud #(
    parameter int WIDTH     = 3,
    parameter int RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              reset,
    gray_counter_ud_if.slave  bus
);
    localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_BIN  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] load_bin;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(bus.load_gray >> i);
        end
    end

    // Next-state selection: load beats enable; boundary steps raise wrap.
    always_comb begin
        bin_nxt  = bin_q;
        gray_nxt = gray_q;
        wrap_nxt = 1'b0;
        if (bus.load) begin
            bin_nxt  = load_bin;
            gray_nxt = bus.load_gray;
        end else if (bus.en) begin
            if (bus.up) begin
                if (bin_q == MAX_BIN) begin
                    wrap_nxt = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                    bin_nxt  = MAX_BIN;
`else
                    bin_nxt  = '0;
`endif
                end else begin
                    bin_nxt = bin_q + ONE;
                end
            end else begin
                if (bin_q == '0) begin
                    wrap_nxt = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
                    bin_nxt  = '0;
`else
                    bin_nxt  = MAX_BIN;
`endif
                end else begin
                    bin_nxt = bin_q - ONE;
                end
            end
            gray_nxt = bin_nxt ^ (bin_nxt >> 1);
        end
    end

    // State register with synchronous reset to the configured index.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign bus.gray = gray_q;
    assign bus.bin  = bin_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_gray_counter_ud.sv
// Purpose: directed self-checking bench for gray_counter_ud (3-bit and 4-bit instances).
// Latency: outputs compared 1 time unit after the edge that consumed the inputs.
// Backpressure: none; every row is one clock.
module tb_gray_counter_ud;
`ifdef GRAY_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [2:0] lg;
        logic [2:0] eg;
        logic [2:0] eb;
        logic       ew;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   passed = 0;

    gray_counter_ud_if #(.WIDTH(3)) ifa ();
    gray_counter_ud_if #(.WIDTH(4)) ifb ();

    gray_counter_ud #(.WIDTH(3), .RESET_VAL(0)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    gray_counter_ud #(.WIDTH(4), .RESET_VAL(5)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic en, logic up, logic load, logic [2:0] lg,
                                logic [2:0] eg, logic [2:0] eb, logic ew);
        vec_t v;
        v.rst = rst; v.en = en; v.up = up; v.load = load; v.lg = lg;
        v.eg = eg; v.eb = eb; v.ew = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive_b(input logic rst, input logic en, input logic up,
                           input logic load, input logic [3:0] lg);
        @(negedge clk);
        rst_b = rst; ifb.en = en; ifb.up = up; ifb.load = load; ifb.load_gray = lg;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string nm, input logic [3:0] eg, input logic [3:0] eb, input logic ew);
        chk({nm, "_gray"}, 32'(ifb.gray), 32'(eg));
        chk({nm, "_bin"},  32'(ifb.bin),  32'(eb));
        chk({nm, "_wrap"}, 32'(ifb.wrap), 32'(ew));
    endtask

    // Instance A: table of rows, one clock each.
    initial begin
        vec_t       tbl[$];
        logic [2:0] prev_gray;
        int         exp_hd;

        rst_a = 1'b1; ifa.en = 1'b0; ifa.up = 1'b0; ifa.load = 1'b0; ifa.load_gray = '0;
        rst_b = 1'b1; ifb.en = 1'b0; ifb.up = 1'b0; ifb.load = 1'b0; ifb.load_gray = '0;
        prev_gray = '0;

        //                  rst en up ld lg      gray    bin     wrap
        if (!SAT) begin
            tbl.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 3'd0, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b001, 3'd1, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 3'd2, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b010, 3'd3, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b110, 3'd4, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b111, 3'd5, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b101, 3'd6, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 3'd7, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b000, 3'd0, 1));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b001, 3'd1, 0));
            // count down from reset
            tbl.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 3'd0, 0));
            tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b100, 3'd7, 1));
            tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b101, 3'd6, 0));
            tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b111, 3'd5, 0));
            tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b110, 3'd4, 0));
        end else begin
            tbl.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 3'd0, 0));
            tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b000, 3'd0, 1));
            tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b000, 3'd0, 1));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b001, 3'd1, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 3'd2, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b010, 3'd3, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b110, 3'd4, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b111, 3'd5, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b101, 3'd6, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 3'd7, 0));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 3'd7, 1));
            tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 3'd7, 1));
            tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b101, 3'd6, 0));
        end
        // hold then reverse direction
        tbl.push_back(mk(1, 0, 0, 0, 3'b000, 3'b000, 3'd0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b001, 3'd1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b011, 3'd2, 0));
        tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b010, 3'd3, 0));
        tbl.push_back(mk(0, 0, 1, 0, 3'b000, 3'b010, 3'd3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3'b000, 3'b010, 3'd3, 0));
        tbl.push_back(mk(0, 0, 1, 0, 3'b000, 3'b010, 3'd3, 0));
        tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b011, 3'd2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b001, 3'd1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 3'b000, 3'b000, 3'd0, 0));
        // load beats enable
        tbl.push_back(mk(0, 1, 1, 1, 3'b110, 3'b110, 3'd4, 0));
        tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b111, 3'd5, 0));
        tbl.push_back(mk(0, 1, 0, 1, 3'b010, 3'b010, 3'd3, 0));
        tbl.push_back(mk(0, 1, 1, 1, 3'b100, 3'b100, 3'd7, 0));
        if (!SAT) tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b000, 3'd0, 1));
        else      tbl.push_back(mk(0, 1, 1, 0, 3'b000, 3'b100, 3'd7, 1));
        // wrap clears on the next idle cycle
        if (!SAT) tbl.push_back(mk(0, 0, 1, 0, 3'b000, 3'b000, 3'd0, 0));
        else      tbl.push_back(mk(0, 0, 1, 0, 3'b000, 3'b100, 3'd7, 0));
        // reset beats load and enable
        tbl.push_back(mk(1, 1, 1, 1, 3'b111, 3'b000, 3'd0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst_a = tbl[i].rst; ifa.en = tbl[i].en; ifa.up = tbl[i].up;
            ifa.load = tbl[i].load; ifa.load_gray = tbl[i].lg;
            @(posedge clk);
            #1;
            chk($sformatf("a%0d_gray", i), 32'(ifa.gray), 32'(tbl[i].eg));
            chk($sformatf("a%0d_bin", i),  32'(ifa.bin),  32'(tbl[i].eb));
            chk($sformatf("a%0d_wrap", i), 32'(ifa.wrap), 32'(tbl[i].ew));
            if (i > 0 && !tbl[i].rst && !tbl[i].load && tbl[i].en) begin
                exp_hd = (tbl[i].eb != tbl[i-1].eb) ? 1 : 0;
                chk($sformatf("a%0d_onebit", i), 32'($countones(ifa.gray ^ prev_gray)), 32'(exp_hd));
            end
            prev_gray = ifa.gray;
        end

        // Instance B: WIDTH=4, RESET_VAL=5
        drive_b(1, 0, 0, 0, 4'b0000);
        chk_b("b_rst", 4'b0111, 4'd5, 0);
        for (int k = 0; k < 6; k++) drive_b(0, 1, 1, 0, 4'b0000);
        chk_b("b_at11", 4'b1110, 4'd11, 0);
        drive_b(1, 1, 1, 0, 4'b0000);
        chk_b("b_midrst", 4'b0111, 4'd5, 0);
        drive_b(0, 1, 1, 0, 4'b0000);
        chk_b("b_resume", 4'b0101, 4'd6, 0);
        drive_b(0, 0, 0, 1, 4'b0000);
        chk_b("b_load0", 4'b0000, 4'd0, 0);
        drive_b(0, 1, 0, 0, 4'b0000);
        if (!SAT) chk_b("b_down_wrap", 4'b1000, 4'd15, 1);
        else      chk_b("b_down_sat",  4'b0000, 4'd0, 1);
        drive_b(0, 1, 1, 1, 4'b1011);
        chk_b("b_load1011", 4'b1011, 4'd13, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gray_counter_ud.md
# gray_counter_ud

Parametrised synchronous up/down Gray-code counter, the general-width successor to the fixed 3-bit modulo-8 Gray counter. It keeps a binary index and registered Gray and binary outputs. It supports enable, direction, a parallel load of a Gray-coded value, and a one-cycle wrap flag. It serves as a pointer or sequence generator wherever single-bit-change state is needed, such as FIFO pointers and position encoders.

## Interface
- WIDTH, 3: counter width in bits; modulus is 2^WIDTH; legal range 2..16.
- RESET_VAL, 0: binary index loaded on reset; must be < 2^WIDTH.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- en  input  1  count enable; 0 holds the current value.
- up  input  1  direction; 1 counts forward in the Gray sequence, 0 counts backward.
- load  input  1  parallel load strobe.
- load_gray  input  WIDTH  value to load, Gray-coded.
- gray  output  WIDTH  registered Gray-coded count.
- bin  output  WIDTH  registered binary index matching gray.
- wrap  output  1  registered one-cycle pulse on boundary event (see Configuration).

## Operation
- Internal state: binary index b (WIDTH bits); gray = b ^ (b >> 1), registered alongside b.
- Priority on each rising clk edge: reset > load > en > hold.
- reset=1: b <= RESET_VAL; gray <= RESET_VAL ^ (RESET_VAL >> 1); wrap <= 0.
- load=1: b <= gray-to-binary(load_gray), where b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i]. gray <= load_gray exactly. wrap <= 0. en and up are ignored.
- en=1, up=1: b <= b + 1, modulo 2^WIDTH.
- en=1, up=0: b <= b - 1, modulo 2^WIDTH.
- en=0: b and gray hold; wrap <= 0.
- Default build, up-count boundary: at b = 2^WIDTH-1, the next value is 0 and wrap <= 1.
- Default build, down-count boundary: at b = 0, the next value is 2^WIDTH-1 and wrap <= 1.
- wrap <= 0 in all other cycles, so it is never held for more than one cycle unless consecutive boundary events occur.
- Successive gray values differ in exactly one bit for every enabled step, including across the wrap.
- Direction may change on any cycle with no penalty; each step uses the up value sampled on that edge.
- No combinational path from any input to any output.

## Timing
- Latency is 1 cycle: input sampled on edge N, outputs valid after edge N.
- gray, bin and wrap update on the same edge and are always mutually consistent.
- Reset asserted mid-count takes effect on the next edge regardless of en or load. The first count after release starts from RESET_VAL.
- load and en asserted together: load wins, and no step is applied that cycle.
- Throughput is one step per cycle while en=1.

## Configuration
- Macro: GRAY_COUNTER_SATURATE_EN.
- Undefined (default): modulo behaviour as above; wrap flags roll-over.
- Defined, up-count at b = 2^WIDTH-1: b holds at the maximum.
- Defined, down-count at b = 0: b holds at 0.
- Defined, blocked step: wrap pulses 1 for one cycle to flag the step that was blocked.
- Defined, all other steps: behave identically to the default build.
- Reset and load are unaffected by the macro.

## Test plan
- Reset then count up (WIDTH=3, RESET_VAL=0): reset 1 cycle, then en=1, up=1 for 9 cycles.
  - Expected gray: 000, 001, 011, 010, 110, 111, 101, 100, 000.
  - wrap=1 only on the cycle showing 000 after 100; bin tracks 0..7, 0.
- Count down from reset: en=1, up=0 from 000.
  - Expected gray: 100, 101, 111, 110.
  - wrap=1 on the first step only.
- Hold and direction change: count up to 010, en=0 for 3 cycles, then en=1, up=0.
  - Expected: 010 held for 3 cycles, then 011, 001, 000.
- Load priority: load=1, load_gray=110, en=1, up=1 in the same cycle.
  - Expected: next gray=110, bin=100, wrap=0.
  - Next step with up=1 gives gray=111.
- Reset mid-operation (RESET_VAL=5, WIDTH=4): count to bin=11, then assert reset with en=1.
  - Expected: next bin=0101, gray=0111, wrap=0.
  - Counting resumes to 0110 after release.
- Saturation (GRAY_COUNTER_SATURATE_EN defined, WIDTH=3): at gray=100 keep up=1 for 2 cycles.
  - Expected: gray stays 100 and wrap=1 on each blocked cycle.
  - A single-bit-change check runs on every enabled step in all builds.
